img_frame_packer: RTL
=====================

Name: img_frame_packer

Overview:
- Parametrised capture-and-pack controller. Sits between the crop/downsample stage of the image capture pipeline and the 256-bit DMEM write port.
- On a CPU enable, waits for the start of a fresh frame and converts each valid pixel (raw, inverted or thresholded). Packs IMG_W*IMG_H pixels LSB-first into WORD_W-bit words and writes them to DMEM from a programmable base address.
- Handshakes completion and short-frame error back to the CPU.

Parameters:
- IMG_W, 28, pixels per line of the downsampled image
- IMG_H, 28, lines per image
- PIX_IN_W, 12, incoming pixel width
- PIX_OUT_W, 8, stored pixel width (must divide WORD_W)
- WORD_W, 256, DMEM write word width
- ADDR_W, 7, DMEM word address width

Ports:
- pxlclk  in  1  pixel clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- iEnable  in  1  CPU capture request, level
- iMode  in  2  00 raw, 01 invert, 10 threshold, 11 treated as raw
- iThresh  in  PIX_IN_W  threshold for mode 10
- iBase  in  ADDR_W  first DMEM word address
- iFVAL  in  1  frame valid from camera
- iDVAL  in  1  pixel valid from downsampler
- iDATA  in  PIX_IN_W  pixel value
- oDone  out  1  capture complete, level
- oErr  out  1  frame ended before IMG_W*IMG_H pixels
- oDmem_wren  out  1  write strobe, one cycle per word
- oDmem_addr  out  ADDR_W  write address
- oDmem_data  out  WORD_W  write data

Behaviour:
- Derived constants: N = IMG_W*IMG_H; PPW = WORD_W/PIX_OUT_W; NWORDS = ceil(N/PPW).
- Reset (rst_n low at a pxlclk edge): state IDLE. oDone=0, oErr=0, oDmem_wren=0, oDmem_addr=0, oDmem_data=0. Pixel count, slot and word index = 0; pack register = 0.
- States: IDLE, ARM_LOW, ARM_HIGH, CAPTURE, FLUSH, DONE.
- IDLE:
  - Wait for iEnable=1.
  - On entry to ARM_LOW, latch iMode, iThresh and iBase; clear counters, pack register and oErr.
- ARM_LOW: wait for iFVAL=0, so a frame already in progress is never captured.
- ARM_HIGH: wait for iFVAL=1, then go to CAPTURE.
- CAPTURE: each cycle with iDVAL=1:
  - Convert the pixel:
    - raw: p = iDATA[PIX_IN_W-1 -: PIX_OUT_W]
    - invert: ~p
    - threshold: all ones if iDATA >= latched thresh (unsigned), else 0
  - Place it at pack[slot*PIX_OUT_W +: PIX_OUT_W]; slot 0 is the LSBs.
  - Increment slot and pixel count.
- Write rule:
  - Trigger: the accepted pixel fills slot PPW-1, or it is pixel N-1.
  - Next cycle: oDmem_wren=1, oDmem_data = pack with unfilled slots zero, oDmem_addr = base + word index mod 2^ADDR_W.
  - Then increment word index, clear pack, reset slot to 0.
  - Latency from the filling iDVAL to wren is 1 cycle.
  - Back-to-back words are allowed when PPW=1.
- Completion: after pixel N-1 is accepted, go to DONE on the cycle its write issues. iDVAL pulses after that are ignored.
- Short frame:
  - iFVAL falls in CAPTURE before N pixels: set oErr=1, go to FLUSH.
  - FLUSH: if slot != 0, issue one write of the partial word (zero padded), then DONE. If slot = 0, go directly to DONE.
  - Words never reached are not written.
- DONE: oDone=1, held until iEnable=0; then oDone=0, go to IDLE. oErr is held until the next capture starts.
- Abort: iEnable=0 in ARM_LOW, ARM_HIGH, CAPTURE or FLUSH returns to IDLE next cycle.
  - No further writes; oDone stays 0.
  - A write already registered that cycle still completes.
- Mid-operation parameter changes: changes to iMode, iThresh or iBase after arming have no effect until the next capture.
- Address wrap: base + index wraps modulo 2^ADDR_W silently.
- oDmem_data holds its last value when wren=0.

Test Plan:
- Raw capture, defaults, base=0: pixel i presented as iDATA = (i mod 256)<<4, DVAL every other cycle -> 25 writes at addr 0..24. Word 0 byte k = k. Word 24 bits[127:0] hold bytes 768..783 (values 0..15), bits[255:128]=0. oDone=1, oErr=0.
- Arm during an active frame: enable asserted while iFVAL=1 mid-frame -> no writes until iFVAL goes 0 then 1. Next frame captured fully, 25 writes.
- Modes:
  - invert on all-0x000 frame -> every written byte 0xFF, last-word padding 0x00.
  - threshold=0x800 with alternating 0x7FF/0x800 pixels -> bytes alternate 0x00/0xFF.
- Short frame: iFVAL falls after 40 pixels -> writes at base, base+1. Second word has bytes 0..7 valid and the rest 0. oErr=1, oDone=1.
- Wrap and abort:
  - base=120 -> addresses 120..127 then 0..16.
  - Separate run: drop iEnable after 100 pixels -> exactly 3 writes total, oDone never asserts, state IDLE.
- Reset and handshake:
  - rst_n low mid-capture -> all outputs 0 next edge, no writes.
  - After DONE, holding iEnable=1 keeps oDone=1. Deassert -> oDone=0 in 1 cycle, and re-enable starts a fresh capture.

Source files
------------

// File: rtl/img_frame_packer.sv
// Capture-and-pack controller: converts valid pixels of one fresh frame and packs
// them LSB-first into wide words written sequentially to DMEM from a base address.
module img_frame_packer #(
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int PIX_IN_W  = 12,
  parameter int PIX_OUT_W = 8,
  parameter int WORD_W    = 256,
  parameter int ADDR_W    = 7
) (
  input  logic                pxlclk,
  input  logic                rst_n,
  input  logic                iEnable,
  input  logic [1:0]          iMode,
  input  logic [PIX_IN_W-1:0] iThresh,
  input  logic [ADDR_W-1:0]   iBase,
  input  logic                iFVAL,
  input  logic                iDVAL,
  input  logic [PIX_IN_W-1:0] iDATA,
  output logic                oDone,
  output logic                oErr,
  output logic                oDmem_wren,
  output logic [ADDR_W-1:0]   oDmem_addr,
  output logic [WORD_W-1:0]   oDmem_data
);

  localparam int N      = IMG_W * IMG_H;
  localparam int PPW    = WORD_W / PIX_OUT_W;
  localparam int CNT_W  = $clog2(N + 1);
  localparam int SLOT_W = (PPW > 1) ? $clog2(PPW) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM_LOW,
    S_ARM_HIGH,
    S_CAPTURE,
    S_FLUSH,
    S_DONE
  } state_e;

  state_e                state_q;
  logic [1:0]            mode_q;
  logic [PIX_IN_W-1:0]   thresh_q;
  logic [ADDR_W-1:0]     base_q;
  logic [CNT_W-1:0]      pix_cnt_q;
  logic [SLOT_W-1:0]     slot_q;
  logic [ADDR_W-1:0]     word_idx_q;
  logic [WORD_W-1:0]     pack_q;
  logic                  done_q;
  logic                  err_q;
  logic                  wren_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [WORD_W-1:0]     data_q;

  logic [PIX_OUT_W-1:0]  pix_raw;
  logic [PIX_OUT_W-1:0]  pix_d;
  logic [WORD_W-1:0]     pack_d;
  logic                  last_slot;
  logic                  last_pix;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    pix_raw = iDATA[PIX_IN_W-1 -: PIX_OUT_W];
    case (mode_q)
      2'b01:   pix_d = ~pix_raw;
      2'b10:   pix_d = (iDATA >= thresh_q) ? '1 : '0;
      default: pix_d = pix_raw;
    endcase
    pack_d = pack_q;
    pack_d[int'(slot_q)*PIX_OUT_W +: PIX_OUT_W] = pix_d;
    last_slot = (slot_q == SLOT_W'(PPW - 1));
    last_pix  = (pix_cnt_q == CNT_W'(N - 1));
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge pxlclk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mode_q     <= '0;
      thresh_q   <= '0;
      base_q     <= '0;
      pix_cnt_q  <= '0;
      slot_q     <= '0;
      word_idx_q <= '0;
      pack_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wren_q     <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      wren_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (iEnable) begin
            state_q    <= S_ARM_LOW;
            mode_q     <= iMode;
            thresh_q   <= iThresh;
            base_q     <= iBase;
            pix_cnt_q  <= '0;
            slot_q     <= '0;
            word_idx_q <= '0;
            pack_q     <= '0;
            err_q      <= 1'b0;
          end
        end
        // Waiting for FVAL low first guarantees we never join a frame mid-way.
        S_ARM_LOW: begin
          if (!iEnable)    state_q <= S_IDLE;
          else if (!iFVAL) state_q <= S_ARM_HIGH;
        end
        S_ARM_HIGH: begin
          if (!iEnable)   state_q <= S_IDLE;
          else if (iFVAL) state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (!iEnable) begin
            state_q <= S_IDLE;
          end else if (!iFVAL) begin
            err_q   <= 1'b1;
            state_q <= S_FLUSH;
          end else if (iDVAL) begin
            pix_cnt_q <= pix_cnt_q + 1'b1;
            if (last_slot || last_pix) begin
              wren_q     <= 1'b1;
              addr_q     <= base_q + word_idx_q;
              data_q     <= pack_d;
              word_idx_q <= word_idx_q + 1'b1;
              pack_q     <= '0;
              slot_q     <= '0;
              if (last_pix) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end
            end else begin
              pack_q <= pack_d;
              slot_q <= slot_q + 1'b1;
            end
          end
        end
        S_FLUSH: begin
          if (!iEnable) begin
            state_q <= S_IDLE;
          end else begin
            // Unfilled slots are already zero because the pack register clears per word.
            if (slot_q != '0) begin
              wren_q     <= 1'b1;
              addr_q     <= base_q + word_idx_q;
              data_q     <= pack_q;
              word_idx_q <= word_idx_q + 1'b1;
              pack_q     <= '0;
              slot_q     <= '0;
            end
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          if (!iEnable) begin
            done_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign oDone      = done_q;
  assign oErr       = err_q;
  assign oDmem_wren = wren_q;
  assign oDmem_addr = addr_q;
  assign oDmem_data = data_q;

endmodule
